// File: rtl/merge_2to1_arb_buffered.sv
// Two-input merge stage: per-port FIFOs feed an external last-served arbiter, and the
// registered grant selects which FIFO head is loaded into a valid/ready output register.

module merge_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wptr_q, wptr_d;
  logic [AW:0]           rptr_q, rptr_d;
  logic                  wr_en;
  logic                  rd_en;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  assign wr_en  = push_i && !full_o;
  assign rd_en  = pop_i && !empty_o;
  assign wptr_d = wr_en ? wptr_q + 1'b1 : wptr_q;
  assign rptr_d = rd_en ? rptr_q + 1'b1 : rptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= data_i;
  end
endmodule

module merge_2to1_arb_buffered #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_data_a,
  input  logic                  i_valid_a,
  output logic                  o_ready_a,
  input  logic [DATA_WIDTH-1:0] i_data_b,
  input  logic                  i_valid_b,
  output logic                  o_ready_b,
  output logic [1:0]            o_arb_req_bus,
  output logic                  o_arb_valid,
  input  logic                  i_arb_valid,
  input  logic                  i_arb_grant_b,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Inputs: i_valid_x / o_ready_x. Output: o_valid / i_ready; o_data holds while stalled.
  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_a, head_b;
  logic                  full_a, full_b, empty_a, empty_b;
  logic                  pop_a, pop_b, load, sel_b, out_free;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  merge_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk(clk), .rst_n(rst_n), .push_i(i_valid_a), .data_i(i_data_a), .pop_i(pop_a),
    .head_o(head_a), .full_o(full_a), .empty_o(empty_a)
  );

  merge_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .push_i(i_valid_b), .data_i(i_data_b), .pop_i(pop_b),
    .head_o(head_b), .full_o(full_b), .empty_o(empty_b)
  );

  assign o_ready_a     = !full_a;
  assign o_ready_b     = !full_b;
  assign o_arb_req_bus = {!empty_b, !empty_a};
  assign out_free      = !valid_q || i_ready;
  // Granted side, falling back to the other FIFO if the granted one is empty.
  assign sel_b         = i_arb_grant_b ? !empty_b : empty_a;

  always_comb begin
    state_d     = state_q;
    o_arb_valid = 1'b0;
    pop_a       = 1'b0;
    pop_b       = 1'b0;
    load        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((|o_arb_req_bus) && out_free) begin
          o_arb_valid = 1'b1;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        state_d = S_IDLE;
        // Skip the pop if downstream stalled since the request; IDLE re-requests.
        if (i_arb_valid && out_free && (!empty_a || !empty_b)) begin
          load  = 1'b1;
          pop_b = sel_b;
          pop_a = !sel_b;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = sel_b ? head_b : head_a;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_dbg_state = state_q;
endmodule

// File: tb/tb_merge_2to1_arb_buffered.sv
// Bench for merge_2to1_arb_buffered: directed steps plus random traffic, a last-served
// arbiter model, and a per-port queue scoreboard for every flit accepted downstream.

module tb_merge_2to1_arb_buffered;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] i_data_a, i_data_b, o_data;
  logic         i_valid_a, i_valid_b, o_ready_a, o_ready_b;
  logic [1:0]   o_arb_req_bus;
  logic         o_arb_valid, o_valid, i_ready, o_dbg_state;
  logic         arb_v, arb_gb, last_b;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] out_log[$];
  logic [W-1:0] exp3[8];
  logic [W-1:0] stall_data;

  merge_2to1_arb_buffered #(.DATA_WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_data_a(i_data_a), .i_valid_a(i_valid_a), .o_ready_a(o_ready_a),
    .i_data_b(i_data_b), .i_valid_b(i_valid_b), .o_ready_b(o_ready_b),
    .o_arb_req_bus(o_arb_req_bus), .o_arb_valid(o_arb_valid),
    .i_arb_valid(arb_v), .i_arb_grant_b(arb_gb),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_dbg_state(o_dbg_state)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // Last-served arbiter: registered grant, one-cycle o_valid pulse per request.
  always @(posedge clk) begin
    if (!rst_n) begin
      arb_v  <= 1'b0;
      arb_gb <= 1'b0;
      last_b <= 1'b1;
    end else if (o_arb_valid) begin
      arb_v <= 1'b1;
      if (o_arb_req_bus == 2'b11) begin
        arb_gb <= !last_b;
        last_b <= !last_b;
      end else begin
        arb_gb <= o_arb_req_bus[1];
        last_b <= o_arb_req_bus[1];
      end
    end else begin
      arb_v <= 1'b0;
    end
  end

  // ---- scoreboard: sampled mid-cycle, describing the coming rising edge ----
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (o_valid && i_ready) begin
        logic hit;
        hit = 1'b0;
        if (qa.size() > 0 && o_data === qa[0]) begin
          void'(qa.pop_front());
          hit = 1'b1;
        end else if (qb.size() > 0 && o_data === qb[0]) begin
          void'(qb.pop_front());
          hit = 1'b1;
        end
        out_log.push_back(o_data);
        checks++;
        assert (hit === 1'b1) else begin
          errors++;
          $error("FAIL sb_flit: observed=%0h expected=head of A %0h or B %0h", o_data,
                 (qa.size() > 0) ? qa[0] : 32'hx, (qb.size() > 0) ? qb[0] : 32'hx);
        end
      end
      if (i_valid_a && o_ready_a) qa.push_back(i_data_a);
      if (i_valid_b && o_ready_b) qb.push_back(i_data_b);
    end
  end

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_valid_a = 1'b0;
    i_valid_b = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    i_valid_a = 1'b0;
    i_valid_b = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 300 && (qa.size() + qb.size() != 0 || o_valid); i++) tick();
    repeat (6) tick();
    chk(tag, qa.size() + qb.size(), 0);
  endtask

  initial begin
    i_data_a = '0;
    i_data_b = '0;
    i_ready = 1'b1;

    // 1. reset
    do_reset();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_arb_valid", o_arb_valid, 0);
    chk("rst_req_bus", o_arb_req_bus, 0);
    chk("rst_ready_a", o_ready_a, 1);
    chk("rst_ready_b", o_ready_b, 1);
    chk("rst_state", o_dbg_state, 0);
    chk("rst_o_data", o_data, 0);

    // 2. single flit latency
    i_valid_a = 1'b1;
    i_data_a = 32'hA5;
    tick();
    i_valid_a = 1'b0;
    chk("lat_request", o_arb_valid, 1);
    tick();
    chk("lat_grant_state", o_dbg_state, 1);
    chk("lat_not_yet", o_valid, 0);
    tick();
    chk("lat_valid", o_valid, 1);
    chk("lat_data", o_data, 32'hA5);
    tick();
    chk("lat_consumed", o_valid, 0);

    // 3. contention with alternating grants
    do_reset();
    out_log.delete();
    for (int k = 0; k < 4; k++) begin
      i_valid_a = 1'b1;
      i_data_a = k + 1;
      i_valid_b = 1'b1;
      i_data_b = k + 11;
      exp3[2*k] = k + 1;
      exp3[2*k+1] = k + 11;
      tick();
    end
    i_valid_a = 1'b0;
    i_valid_b = 1'b0;
    for (int i = 0; i < 100 && out_log.size() < 8; i++) tick();
    repeat (4) tick();
    chk("cont_count", out_log.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("cont_flit%0d", i), (i < out_log.size()) ? out_log[i] : 32'hDEADBEEF, exp3[i]);

    // 4. full FIFO A behind a stalled output
    i_ready = 1'b0;
    stall_data = 32'h8000_0055;
    i_valid_b = 1'b1;
    i_data_b = stall_data;
    tick();
    i_valid_b = 1'b0;
    repeat (3) tick();
    chk("stall_valid", o_valid, 1);
    chk("stall_data", o_data, stall_data);
    for (int k = 0; k < 5; k++) begin
      i_valid_a = 1'b1;
      i_data_a = 32'h100 + k;
      tick();
      if (k == 2) chk("full_ready_after3", o_ready_a, 1);
      if (k == 3) chk("full_ready_after4", o_ready_a, 0);
    end
    i_valid_a = 1'b0;
    chk("full_ready_after5", o_ready_a, 0);

    // 5. backpressure hold
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_data", o_data, stall_data);
      chk("bp_valid", o_valid, 1);
      chk("bp_arb_valid", o_arb_valid, 0);
      chk("bp_ready_a", o_ready_a, 0);
      chk("bp_req_bus", o_arb_req_bus, 2'b01);
    end
    drain("bp_drain");

    // 6. reset in the GRANT cycle
    i_valid_a = 1'b1;
    i_data_a = 32'h10;
    i_valid_b = 1'b1;
    i_data_b = 32'h8000_0020;
    tick();
    i_data_a = 32'h11;
    i_valid_b = 1'b0;
    chk("mid_request", o_arb_valid, 1);
    tick();
    i_valid_a = 1'b0;
    chk("mid_in_grant", o_dbg_state, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_o_valid", o_valid, 0);
    chk("mid_req_bus", o_arb_req_bus, 0);
    chk("mid_ready_a", o_ready_a, 1);
    chk("mid_ready_b", o_ready_b, 1);
    chk("mid_state", o_dbg_state, 0);
    repeat (4) tick();
    chk("mid_nothing_after", o_valid, 0);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      i_valid_a = o_ready_a && ($urandom_range(0, 2) != 0);
      i_data_a = {1'b0, 31'($urandom)};
      i_valid_b = o_ready_b && ($urandom_range(0, 2) != 0);
      i_data_b = {1'b1, 31'($urandom)};
      i_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand_drain");

    // ---- report ----
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
